// File: rtl/rijndael_pkg.sv
// Shared Rijndael types and GF(2^8) helpers for the column mixing datapath.
package rijndael_pkg;

  localparam logic MC_FWD = 1'b0;
  localparam logic MC_INV = 1'b1;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_BUSY,
    MC_DONE
  } mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the coefficients used by the forward and inverse matrices are supported.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] coeff);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (coeff)
      8'h01:   return x;
      8'h02:   return x2;
      8'h03:   return x2 ^ x;
      8'h09:   return x8 ^ x;
      8'h0b:   return x8 ^ x2 ^ x;
      8'h0d:   return x8 ^ x4 ^ x;
      8'h0e:   return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rijndael_mixcolumn_word.sv
// Combinational forward/inverse MixColumns on one 32-bit column (row 0 in the MSBs).
module rijndael_mixcolumn_word
  import rijndael_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);

  logic [7:0] a [4];
  logic [7:0] m [4];

  // Circulant matrix: row r uses coefficient m[i] against byte (r+i) mod 4.
  always_comb begin
    col_o = '0;
    m[0]  = (inv_i == MC_INV) ? 8'h0e : 8'h02;
    m[1]  = (inv_i == MC_INV) ? 8'h0b : 8'h03;
    m[2]  = (inv_i == MC_INV) ? 8'h0d : 8'h01;
    m[3]  = (inv_i == MC_INV) ? 8'h09 : 8'h01;
    for (int r = 0; r < 4; r++) begin
      a[r] = col_i[31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      col_o[31-8*r -: 8] = gf_mul(a[r],            m[0])
                         ^ gf_mul(a[(r + 1) % 4], m[1])
                         ^ gf_mul(a[(r + 2) % 4], m[2])
                         ^ gf_mul(a[(r + 3) % 4], m[3]);
    end
  end

endmodule

// File: rtl/rijndael_mixcolumns_iter.sv
// Iterative handshaked MixColumns/InvMixColumns: mixes COLS_PER_CYCLE columns per
// cycle in place in a work register, then presents the whole state.
module rijndael_mixcolumns_iter
  import rijndael_pkg::*;
#(
  parameter  int unsigned NB             = 4,
  parameter  int unsigned COLS_PER_CYCLE = 1,
  localparam int unsigned STATESIZE      = 32 * NB
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 inv_i,
  input  logic [STATESIZE-1:0] state_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [STATESIZE-1:0] state_o
);

  localparam int unsigned NGROUPS = NB / COLS_PER_CYCLE;
  localparam int unsigned CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int unsigned GRP_W   = 32 * COLS_PER_CYCLE;

  if ((NB % COLS_PER_CYCLE) != 0 || !(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_param
    $error("rijndael_mixcolumns_iter: NB must be 4/6/8 and divisible by COLS_PER_CYCLE");
  end

  mc_state_e             state_q, state_d;
  logic [STATESIZE-1:0]  work_q,  work_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  mode_q,  mode_d;
  logic                  fin_q,   fin_d;
  logic [GRP_W-1:0]      grp_in;
  logic [GRP_W-1:0]      grp_out;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MC_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MC_FWD;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fin_q   <= fin_d;
    end
  end

  // Next-state: BUSY spends one closing cycle after the last group before DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MC_IDLE: if (valid_i) state_d = MC_BUSY;
      MC_BUSY: if (fin_q)   state_d = MC_DONE;
      MC_DONE: if (ready_i) state_d = MC_IDLE;
      default:              state_d = MC_IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes.
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    ready_o = (state_q == MC_IDLE);
    valid_o = (state_q == MC_DONE);
  end

  assign state_o = work_q;

  // Column group select by counter
  always_comb begin
    grp_in = '0;
    for (int unsigned g = 0; g < NGROUPS; g++) begin
      if (cnt_q == CNT_W'(g)) grp_in = work_q[STATESIZE-1-GRP_W*g -: GRP_W];
    end
  end

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_mix
    rijndael_mixcolumn_word u_mix (
      .col_i (grp_in [GRP_W-1-32*j -: 32]),
      .inv_i (mode_q),
      .col_o (grp_out[GRP_W-1-32*j -: 32])
    );
  end

  // Capture on accept; in-place group write-back while BUSY.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    fin_d  = fin_q;
    case (state_q)
      MC_IDLE: begin
        if (valid_i) begin
          work_d = state_i;
          mode_d = inv_i;
          cnt_d  = '0;
          fin_d  = 1'b0;
        end
      end
      MC_BUSY: begin
        if (!fin_q) begin
          for (int unsigned g = 0; g < NGROUPS; g++) begin
            if (cnt_q == CNT_W'(g)) work_d[STATESIZE-1-GRP_W*g -: GRP_W] = grp_out;
          end
          if (cnt_q == CNT_W'(NGROUPS - 1)) fin_d = 1'b1;
          else                              cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rijndael_mixcolumns_iter.sv
// Self-checking bench: nine NB/COLS_PER_CYCLE configurations against an
// independent GF(2^8) matrix model.
module tb_rijndael_mixcolumns_iter;

  localparam int NCFG = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vld_i [NCFG];
  logic         rdy_o [NCFG];
  logic         inv_i [NCFG];
  logic [255:0] st_i  [NCFG];
  logic         vld_o [NCFG];
  logic         rdy_i [NCFG];
  logic [255:0] st_o  [NCFG];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int unsigned NB_L  = (g < 3) ? 4 : ((g < 6) ? 6 : 8);
    localparam int unsigned CPC_L = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : NB_L);
    logic [32*NB_L-1:0] so;
    rijndael_mixcolumns_iter #(.NB(NB_L), .COLS_PER_CYCLE(CPC_L)) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .valid_i (vld_i[g]),
      .ready_o (rdy_o[g]),
      .inv_i   (inv_i[g]),
      .state_i (st_i[g][32*NB_L-1:0]),
      .valid_o (vld_o[g]),
      .ready_i (rdy_i[g]),
      .state_o (so)
    );
    assign st_o[g] = 256'(so);
  end

  function automatic int nb_of(input int g);
    return (g < 3) ? 4 : ((g < 6) ? 6 : 8);
  endfunction

  function automatic int cpc_of(input int g);
    return (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : nb_of(g));
  endfunction

  // Shift-and-add multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [8:0] t;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      t = {a, 1'b0};
      if (t[8]) t = t ^ 9'h11b;
      a = t[7:0];
    end
    return p;
  endfunction

  function automatic logic [255:0] mix_ref(input logic [255:0] s, input int nb, input logic inv);
    logic [7:0]   row [4];
    logic [7:0]   a   [4];
    logic [7:0]   b;
    logic [255:0] out = '0;
    if (inv) begin
      row[0] = 8'h0e; row[1] = 8'h0b; row[2] = 8'h0d; row[3] = 8'h09;
    end else begin
      row[0] = 8'h02; row[1] = 8'h03; row[2] = 8'h01; row[3] = 8'h01;
    end
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) a[r] = 8'(s >> (32*nb - 8 - 32*c - 8*r));
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int i = 0; i < 4; i++) b = b ^ gmul(row[(i - r + 4) % 4], a[i]);
        out = out | (256'(b) << (32*nb - 8 - 32*c - 8*r));
      end
    end
    return out;
  endfunction

  function automatic logic [255:0] rand_state(input int nb);
    logic [255:0] v = '0;
    for (int i = 0; i < nb; i++) v = (v << 32) | 256'($urandom());
    return v;
  endfunction

  function automatic logic [255:0] rep_col(input logic [31:0] col, input int nb);
    logic [255:0] v = '0;
    for (int i = 0; i < nb; i++) v = (v << 32) | 256'(col);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Offer one state at the next edge, then count edges until valid_o is seen.
  task automatic xfer(input int g, input logic [255:0] s, input logic inv,
                      output logic [255:0] res, output int lat);
    vld_i[g] = 1'b1;
    st_i[g]  = s;
    inv_i[g] = inv;
    @(posedge clk); #1;
    vld_i[g] = 1'b0;
    st_i[g]  = rand_state(8);
    inv_i[g] = ~inv;
    lat = 0;
    while (!vld_o[g] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    res = st_o[g];
    if (rdy_i[g]) begin
      @(posedge clk); #1;
    end
  endtask

  logic [255:0] s, e, r1, r2;
  int           lat;
  logic         inv;

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < NCFG; g++) begin
      vld_i[g] = 1'b0; inv_i[g] = 1'b0; st_i[g] = '0; rdy_i[g] = 1'b1;
    end
    @(posedge clk); @(posedge clk); #1;
    for (int g = 0; g < NCFG; g++) begin
      chk("rst_ready", 256'(rdy_o[g]), 256'(1));
      chk("rst_valid", 256'(vld_o[g]), 256'(0));
      chk("rst_state", st_o[g], '0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known forward and inverse vectors, NB=4 CPC=1
    s = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
    e = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
    xfer(0, s, 1'b0, r1, lat);
    chk("fwd_vec", r1, e);
    chk("fwd_lat", 256'(lat), 256'(5));
    chk("post_hs_ready", 256'(rdy_o[0]), 256'(1));
    xfer(0, e, 1'b1, r1, lat);
    chk("inv_vec", r1, s);
    chk("inv_lat", 256'(lat), 256'(5));

    // Forward then inverse round trip
    for (int n = 0; n < 100; n++) begin
      s = rand_state(4);
      xfer(0, s, 1'b0, r1, lat);
      chk("rt_fwd", r1, mix_ref(s, 4, 1'b0));
      xfer(0, r1, 1'b1, r2, lat);
      chk("rt_inv", r2, s);
    end

    // Backpressure in DONE with stray valid_i pulses
    rdy_i[0] = 1'b0;
    s = rand_state(4);
    e = mix_ref(s, 4, 1'b0);
    xfer(0, s, 1'b0, r1, lat);
    chk("bp_lat", 256'(lat), 256'(5));
    chk("bp_res", r1, e);
    for (int i = 0; i < 10; i++) begin
      vld_i[0] = 1'($urandom_range(0, 1));
      st_i[0]  = rand_state(4);
      inv_i[0] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("bp_valid", 256'(vld_o[0]), 256'(1));
      chk("bp_state", st_o[0], e);
      chk("bp_ready", 256'(rdy_o[0]), 256'(0));
    end
    vld_i[0] = 1'b0;
    rdy_i[0] = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid", 256'(vld_o[0]), 256'(0));
    chk("hs_ready", 256'(rdy_o[0]), 256'(1));
    chk("hs_hold",  st_o[0], e);
    @(posedge clk); #1;
    chk("hs_single", 256'(vld_o[0]), 256'(0));
    chk("hs_hold2",  st_o[0], e);

    // Reset after two BUSY cycles
    vld_i[0] = 1'b1;
    st_i[0]  = rand_state(4);
    inv_i[0] = 1'b0;
    @(posedge clk); #1;
    vld_i[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 256'(vld_o[0]), 256'(0));
    chk("mid_rst_ready", 256'(rdy_o[0]), 256'(1));
    chk("mid_rst_state", st_o[0], '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_novalid", 256'(vld_o[0]), 256'(0));
    end
    xfer(0, rep_col(32'hd4d4d4d5, 4), 1'b0, r1, lat);
    chk("post_rst_vec", r1, rep_col(32'hd5d5d7d6, 4));
    chk("post_rst_lat", 256'(lat), 256'(5));

    // Parameter sweep
    for (int g = 0; g < NCFG; g++) begin
      for (int n = 0; n < 200; n++) begin
        s   = rand_state(nb_of(g));
        inv = 1'($urandom_range(0, 1));
        xfer(g, s, inv, r1, lat);
        chk("sweep_res", r1, mix_ref(s, nb_of(g), inv));
        chk("sweep_lat", 256'(lat), 256'(nb_of(g) / cpc_of(g) + 1));
      end
      xfer(g, rep_col(32'h2d26314c, nb_of(g)), 1'b0, r1, lat);
      chk("sweep_colvec", r1, rep_col(32'h4d7ebdf8, nb_of(g)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

endmodule
